// File: rtl/rvc_instr_aligner.sv
// rtl/rvc_instr_aligner.sv - halfword realignment buffer between fetch and the RVC decompressor
module rvc_instr_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_fetch_valid,
    input  logic [31:0] i_fetch_data,
    output logic        o_fetch_ready,
    input  logic        i_flush,
    input  logic [31:0] i_flush_pc,
    output logic        o_instr_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    output logic        o_is_compressed,
    input  logic        i_instr_ready
);

    // Parcel queue, index 0 is the oldest (head) parcel.
    logic [2:0][15:0] queue_q, queue_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [31:0]      pc_q, pc_d;
    logic             skip_q, skip_d;

    logic             head_c;
    logic             fetch_hs;
    logic             instr_hs;
    logic [1:0]       deq;
    logic [1:0]       enq;
    logic [1:0]       base;

    // Output decode and handshake qualification, all from registered state plus the flush gate.
    always_comb begin
        head_c          = (queue_q[0][1:0] != 2'b11);
        o_fetch_ready   = (cnt_q <= 2'd1) && !i_flush;
        o_instr_valid   = !i_flush && (((cnt_q >= 2'd1) && head_c) || (cnt_q >= 2'd2));
        o_instr         = head_c ? {16'h0000, queue_q[0]} : {queue_q[1], queue_q[0]};
        o_is_compressed = head_c;
        o_instr_pc      = pc_q;

        fetch_hs = i_fetch_valid && o_fetch_ready;
        instr_hs = o_instr_valid && i_instr_ready;
        deq      = instr_hs ? (head_c ? 2'd1 : 2'd2) : 2'd0;
        enq      = fetch_hs ? (skip_q ? 2'd1 : 2'd2) : 2'd0;
        base     = cnt_q - deq;
    end

    // Next-state: shift out consumed parcels, append the fetched ones behind the survivors.
    always_comb begin
        queue_d = queue_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        skip_d  = skip_q;

        case (deq)
            2'd1:    queue_d = {16'h0000, queue_q[2], queue_q[1]};
            2'd2:    queue_d = {16'h0000, 16'h0000, queue_q[2]};
            default: queue_d = queue_q;
        endcase

        // Fetch is only accepted with cnt <= 1, so base + enq never exceeds 3.
        if (fetch_hs) begin
            if (skip_q) begin
                queue_d[base] = i_fetch_data[31:16];
            end else begin
                queue_d[base]         = i_fetch_data[15:0];
                queue_d[base + 2'd1]  = i_fetch_data[31:16];
            end
            skip_d = 1'b0;
        end

        cnt_d = cnt_q - deq + enq;

        if (instr_hs) begin
            pc_d = pc_q + (head_c ? 32'd2 : 32'd4);
        end

        // Redirect wins over both handshakes; both are already gated off by i_flush.
        if (i_flush) begin
            cnt_d  = 2'd0;
            pc_d   = {i_flush_pc[31:1], 1'b0};
            skip_d = i_flush_pc[1];
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            queue_q <= '0;
            cnt_q   <= 2'd0;
            pc_q    <= RESET_PC;
            skip_q  <= RESET_PC[1];
        end else begin
            queue_q <= queue_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            skip_q  <= skip_d;
        end
    end

endmodule
